// File: rtl/ccc_frame_tracker_if.sv
// rtl/ccc_frame_tracker_if.sv - CCC frame tracker configuration, bit-counter and status bundle
interface ccc_frame_tracker_if #(
    parameter int LEN_W = 16,
    parameter int BIT_W = 6
);
    logic             i_fcnt_en;
    logic             i_regf_CMD_ATTR;
    logic [LEN_W-1:0] i_regf_DATA_LEN;
    logic [2:0]       i_regf_DTT;
    logic             i_ccc_Direct_Broadcast_n;
    logic [BIT_W-1:0] i_cnt_bit_count;
    logic             i_bitcnt_toggle;
    logic             o_cccnt_last_frame;
    logic             o_fcnt_done;
    logic             o_fcnt_overrun;
    logic [LEN_W:0]   o_fcnt_remaining;

    modport master (
        output i_fcnt_en, i_regf_CMD_ATTR, i_regf_DATA_LEN, i_regf_DTT,
               i_ccc_Direct_Broadcast_n, i_cnt_bit_count, i_bitcnt_toggle,
        input  o_cccnt_last_frame, o_fcnt_done, o_fcnt_overrun, o_fcnt_remaining
    );

    modport slave (
        input  i_fcnt_en, i_regf_CMD_ATTR, i_regf_DATA_LEN, i_regf_DTT,
               i_ccc_Direct_Broadcast_n, i_cnt_bit_count, i_bitcnt_toggle,
        output o_cccnt_last_frame, o_fcnt_done, o_fcnt_overrun, o_fcnt_remaining
    );
endinterface

// File: rtl/ccc_frame_tracker.sv
// rtl/ccc_frame_tracker.sv - HDR CCC frame tracker: remaining units, last-frame, done and overrun
module ccc_frame_tracker #(
    parameter int LEN_W      = 16,
    parameter int BIT_W      = 6,
    parameter int FRAME_BITS = 20,
    parameter int DIRECT_OVH = 5,
    parameter int BCAST_OVH  = 1
) (
    input  logic                 i_fcnt_clk,
    input  logic                 i_fcnt_rst_n,
    ccc_frame_tracker_if.slave   bus
);
    localparam int CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAST, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic [CNT_W-1:0] imm_base;
    logic [CNT_W-1:0] load_val;
    logic             unit_b;

    // A unit is half an HDR word, so both the mid-word and end-of-word bits close one.
    always_comb begin
        unit_b = bus.i_bitcnt_toggle &&
                 ((bus.i_cnt_bit_count == BIT_W'(FRAME_BITS/2 - 1)) ||
                  (bus.i_cnt_bit_count == BIT_W'(FRAME_BITS - 1)));
    end

    always_comb begin
        imm_base = CNT_W'(1);
        case (bus.i_regf_DTT)
            3'd0, 3'd5: imm_base = CNT_W'(1);
            3'd1, 3'd6: imm_base = CNT_W'(2);
            3'd2, 3'd7: imm_base = CNT_W'(3);
            3'd3:       imm_base = CNT_W'(4);
            3'd4:       imm_base = CNT_W'(5);
            default:    imm_base = CNT_W'(1);
        endcase
    end

    // Single-unit immediates carry no direct overhead.
    always_comb begin
        load_val = '0;
        if (!bus.i_regf_CMD_ATTR) begin
            load_val = {1'b0, bus.i_regf_DATA_LEN} +
                       (bus.i_ccc_Direct_Broadcast_n ? CNT_W'(DIRECT_OVH) : CNT_W'(BCAST_OVH));
        end else if (!bus.i_ccc_Direct_Broadcast_n || imm_base == CNT_W'(1)) begin
            load_val = imm_base;
        end else begin
            load_val = imm_base + CNT_W'(DIRECT_OVH - BCAST_OVH);
        end
    end

    always_ff @(posedge i_fcnt_clk) begin
        if (!i_fcnt_rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.i_fcnt_en) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: state_d = (load_val == '0) ? S_LAST : S_RUN;
                S_RUN:  if (unit_b && rem_q == CNT_W'(1)) state_d = S_LAST;
                S_LAST: if (unit_b) state_d = S_DONE;
                S_DONE: state_d = S_DONE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Disable outranks a coincident unit boundary; idle keeps reloading the config.
    always_comb begin
        rem_d  = rem_q;
        last_d = last_q;
        done_d = 1'b0;
        ovr_d  = ovr_q;
        if (!bus.i_fcnt_en || state_q == S_IDLE) begin
            rem_d  = load_val;
            last_d = bus.i_fcnt_en && (load_val == '0);
            ovr_d  = 1'b0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (unit_b && rem_q != '0) begin
                        rem_d = rem_q - CNT_W'(1);
                        if (rem_q == CNT_W'(1)) last_d = 1'b1;
                    end
                end
                S_LAST: begin
                    last_d = 1'b1;
                    if (unit_b) done_d = 1'b1;
                end
                S_DONE: begin
                    last_d = 1'b1;
                    if (unit_b) ovr_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_cccnt_last_frame = last_q;
    assign bus.o_fcnt_done        = done_q;
    assign bus.o_fcnt_overrun     = ovr_q;
    assign bus.o_fcnt_remaining   = rem_q;
endmodule

// File: tb/tb_ccc_frame_tracker.sv
// tb/tb_ccc_frame_tracker.sv - directed self-checking bench for ccc_frame_tracker
module tb_ccc_frame_tracker;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ccc_frame_tracker_if #(.LEN_W(16), .BIT_W(6)) bus ();

    ccc_frame_tracker #(
        .LEN_W(16), .BIT_W(6), .FRAME_BITS(20), .DIRECT_OVH(5), .BCAST_OVH(1)
    ) dut (
        .i_fcnt_clk  (clk),
        .i_fcnt_rst_n(rst_n),
        .bus         (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic unit_b(input bit hi);
        bus.i_cnt_bit_count = hi ? 6'd19 : 6'd9;
        bus.i_bitcnt_toggle = 1'b1;
        tick();
        bus.i_bitcnt_toggle = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [31:0] rem,
                             input logic last, input logic done, input logic ovr);
        check({tag, ".rem"},  32'(bus.o_fcnt_remaining),   rem);
        check({tag, ".last"}, 32'(bus.o_cccnt_last_frame), 32'(last));
        check({tag, ".done"}, 32'(bus.o_fcnt_done),        32'(done));
        check({tag, ".ovr"},  32'(bus.o_fcnt_overrun),     32'(ovr));
    endtask

    task automatic cfg(input logic attr, input logic [15:0] len,
                       input logic [2:0] dtt, input logic dir);
        bus.i_regf_CMD_ATTR          = attr;
        bus.i_regf_DATA_LEN          = len;
        bus.i_regf_DTT               = dtt;
        bus.i_ccc_Direct_Broadcast_n = dir;
    endtask

    typedef struct {
        logic        attr;
        logic [15:0] len;
        logic [2:0]  dtt;
        logic        dir;
        logic [16:0] exp_l;
    } load_vec_t;

    load_vec_t lv[10];

    initial begin
        rst_n               = 1'b0;
        bus.i_fcnt_en       = 1'b0;
        bus.i_cnt_bit_count = '0;
        bus.i_bitcnt_toggle = 1'b0;
        cfg(1'b0, 16'd3, 3'd0, 1'b1);
        tick();
        tick();
        check_out("reset", 0, 0, 0, 0);

        rst_n = 1'b1;
        tick();
        check_out("idle_reload", 8, 0, 0, 0);
        bus.i_fcnt_en = 1'b1;
        tick();
        check_out("run_entry", 8, 0, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            unit_b(i[0]);
            check_out($sformatf("dir_b%0d", i), 32'(8 - i), i == 8, 0, 0);
        end
        bus.i_cnt_bit_count = 6'd5;
        bus.i_bitcnt_toggle = 1'b1;
        tick();
        bus.i_bitcnt_toggle = 1'b0;
        check_out("non_boundary", 0, 1, 0, 0);
        unit_b(1'b0);
        check_out("done_pulse", 0, 1, 1, 0);
        tick();
        check_out("done_drop", 0, 1, 0, 0);
        unit_b(1'b1);
        check_out("ovr_set", 0, 1, 0, 1);
        unit_b(1'b0);
        check_out("ovr_hold", 0, 1, 0, 1);
        bus.i_fcnt_en = 1'b0;
        tick();
        check_out("ovr_clear", 8, 0, 0, 0);

        // Load-value table: regular/immediate, direct/broadcast, boundary lengths.
        lv[0] = '{1'b1, 16'd0,      3'd2, 1'b0, 17'd3};
        lv[1] = '{1'b1, 16'd0,      3'd4, 1'b1, 17'd9};
        lv[2] = '{1'b1, 16'd0,      3'd5, 1'b1, 17'd1};
        lv[3] = '{1'b1, 16'd0,      3'd5, 1'b0, 17'd1};
        lv[4] = '{1'b1, 16'd0,      3'd0, 1'b1, 17'd1};
        lv[5] = '{1'b1, 16'd0,      3'd7, 1'b1, 17'd7};
        lv[6] = '{1'b1, 16'd0,      3'd3, 1'b0, 17'd4};
        lv[7] = '{1'b0, 16'hFFFF,   3'd0, 1'b1, 17'h10004};
        lv[8] = '{1'b0, 16'hFFFF,   3'd0, 1'b0, 17'h10000};
        lv[9] = '{1'b0, 16'd0,      3'd0, 1'b0, 17'd1};
        foreach (lv[k]) begin
            cfg(lv[k].attr, lv[k].len, lv[k].dtt, lv[k].dir);
            tick();
            check($sformatf("load%0d", k), 32'(bus.o_fcnt_remaining), 32'(lv[k].exp_l));
        end

        cfg(1'b1, 16'd0, 3'd2, 1'b0);
        tick();
        bus.i_fcnt_en = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            unit_b(1'b0);
            check_out($sformatf("imm_b%0d", i), 32'(3 - i), i == 3, 0, 0);
        end
        unit_b(1'b1);
        check_out("imm_done", 0, 1, 1, 0);

        bus.i_fcnt_en = 1'b0;
        cfg(1'b0, 16'hFFFF, 3'd0, 1'b1);
        tick();
        bus.i_fcnt_en = 1'b1;
        tick();
        check_out("wide_run", 32'h10004, 0, 0, 0);
        unit_b(1'b0);
        check_out("wide_dec", 32'h10003, 0, 0, 0);

        bus.i_fcnt_en = 1'b0;
        cfg(1'b0, 16'd3, 3'd0, 1'b1);
        tick();
        bus.i_fcnt_en = 1'b1;
        tick();
        unit_b(1'b0);
        unit_b(1'b1);
        check_out("abort_pre", 6, 0, 0, 0);
        cfg(1'b0, 16'd10, 3'd0, 1'b1);
        unit_b(1'b0);
        check_out("cfg_ignored", 5, 0, 0, 0);
        bus.i_fcnt_en       = 1'b0;
        bus.i_cnt_bit_count = 6'd9;
        bus.i_bitcnt_toggle = 1'b1;
        tick();
        bus.i_bitcnt_toggle = 1'b0;
        check_out("abort", 15, 0, 0, 0);

        cfg(1'b0, 16'd0, 3'd0, 1'b0);
        tick();
        bus.i_fcnt_en = 1'b1;
        tick();
        check_out("short_run", 1, 0, 0, 0);
        unit_b(1'b0);
        check_out("short_last", 0, 1, 0, 0);
        rst_n               = 1'b0;
        bus.i_cnt_bit_count = 6'd19;
        bus.i_bitcnt_toggle = 1'b1;
        tick();
        bus.i_bitcnt_toggle = 1'b0;
        check_out("rst_in_last", 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();
        check_out("rst_restart", 1, 0, 0, 0);
        unit_b(1'b1);
        check_out("rst_relast", 0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
